// File: rtl/psum_accumulator.sv
// psum_accumulator: sums a stream of partial sums (one per beat, vector end
// flagged by in_last) into a wide accumulator and emits one result per vector
// over a valid/ready handshake. Optional saturation, sticky per-vector
// overflow flag, and a sticky length-error flag.
module psum_accumulator #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_ACC = 32,
  parameter bit SIGNED    = 1'b1,
  parameter bit SATURATE  = 1'b1,
  parameter int MAX_LEN   = 256,
  localparam int CW       = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] out_data,
  output logic [CW-1:0]        out_count,
  output logic                 out_ovf,
  output logic                 len_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  localparam int                   MSB     = WIDTH_ACC - 1;
  localparam logic [WIDTH_ACC-1:0] SMAX    = {1'b0, {MSB{1'b1}}};
  localparam logic [WIDTH_ACC-1:0] SMIN    = {1'b1, {MSB{1'b0}}};
  localparam logic [WIDTH_ACC-1:0] UMAX    = {WIDTH_ACC{1'b1}};
  localparam logic [CW-1:0]        CNT_MAX = CW'(MAX_LEN);

  logic [0:0]           state;
  logic [WIDTH_ACC-1:0] acc;
  logic [CW-1:0]        count;
  logic                 ovf;

  logic [WIDTH_ACC-1:0] ext;
  logic [WIDTH_ACC-1:0] base;
  logic [WIDTH_ACC:0]   sum_full;
  logic [WIDTH_ACC-1:0] sum_sel;
  logic                 beat_ovf;
  logic                 ovf_next;
  logic [CW-1:0]        cnt_base;
  logic [CW-1:0]        cnt_next;
  logic                 at_max;
  logic                 accept;

  // Widen the incoming partial sum to accumulator width.
  if (SIGNED) begin : g_sext
    assign ext = WIDTH_ACC'($signed(in_data));
  end else begin : g_zext
    assign ext = WIDTH_ACC'(in_data);
  end

  // Stall while a result is waiting; flush also blocks the beat it coincides with.
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Next accumulator value, overflow and beat count for the beat on the inputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    base     = (state == IDLE) ? '0 : acc;
    cnt_base = (state == IDLE) ? '0 : count;
    sum_full = {1'b0, base} + {1'b0, ext};
    sum_sel  = sum_full[MSB:0];
    // Signed overflow equals carry-out XOR carry-into-MSB, which is the same as
    // "operand signs agree and the result sign differs".
    beat_ovf = SIGNED ? (sum_full[WIDTH_ACC] ^ sum_full[MSB] ^ base[MSB] ^ ext[MSB])
                      : sum_full[WIDTH_ACC];
    if (SATURATE && beat_ovf) begin
      // On signed overflow both operands share a sign, so base[MSB] picks the rail.
      sum_sel = SIGNED ? (base[MSB] ? SMIN : SMAX) : UMAX;
    end
    ovf_next = ((state == IDLE) ? 1'b0 : ovf) | beat_ovf;
    at_max   = (cnt_base == CNT_MAX);
    cnt_next = at_max ? cnt_base : cnt_base + CW'(1);
  end

  // Vector state, accumulator and result register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (flush) begin
        state <= IDLE;
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end else if (accept) begin
        if (at_max) begin
          len_err <= 1'b1;
        end
        if (in_last) begin
          // A new result overrides the transfer clear above: back-to-back, no bubble.
          state     <= IDLE;
          acc       <= '0;
          count     <= '0;
          ovf       <= 1'b0;
          out_valid <= 1'b1;
          out_data  <= sum_sel;
          out_count <= cnt_next;
          out_ovf   <= ovf_next;
        end else begin
          state <= ACC;
          acc   <= sum_sel;
          count <= cnt_next;
          ovf   <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed and randomized checks of psum_accumulator over
// five parameterizations sharing one input stream.
module tb_psum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic [4:0]  in_ready, out_valid, out_ovf, len_err;
  logic [31:0] od0, od3;
  logic [15:0] od1, od2, od4;
  logic [8:0]  oc0, oc1, oc2, oc4;
  logic [2:0]  oc3;

  int checks   = 0;
  int failures = 0;

  // d0: defaults (16 -> 32, signed, saturating, MAX_LEN 256)
  psum_accumulator u_d0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_data(od0), .out_count(oc0), .out_ovf(out_ovf[0]), .len_err(len_err[0]));
  // d1: 16-bit accumulator, signed, saturating
  psum_accumulator #(.WIDTH_ACC(16)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_data(od1), .out_count(oc1), .out_ovf(out_ovf[1]), .len_err(len_err[1]));
  // d2: 16-bit accumulator, signed, wrapping
  psum_accumulator #(.WIDTH_ACC(16), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_data(od2), .out_count(oc2), .out_ovf(out_ovf[2]), .len_err(len_err[2]));
  // d3: short vectors (MAX_LEN 4)
  psum_accumulator #(.MAX_LEN(4)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[3]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid[3]), .out_ready(out_ready),
    .out_data(od3), .out_count(oc3), .out_ovf(out_ovf[3]), .len_err(len_err[3]));
  // d4: 16-bit accumulator, unsigned, saturating
  psum_accumulator #(.WIDTH_ACC(16), .SIGNED(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[4]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid[4]), .out_ready(out_ready),
    .out_data(od4), .out_count(oc4), .out_ovf(out_ovf[4]), .len_err(len_err[4]));

  // Per-instance configuration and output selection.
  function automatic bit cfg_sgn(input int k);   return k != 4;                                 endfunction
  function automatic bit cfg_sat(input int k);   return k != 2;                                 endfunction
  function automatic int cfg_wacc(input int k);  return (k == 1 || k == 2 || k == 4) ? 16 : 32; endfunction
  function automatic int cfg_max(input int k);   return (k == 3) ? 4 : 256;                     endfunction

  function automatic longint get_data(input int k);
    case (k)
      0:       return longint'(od0);
      1:       return longint'(od1);
      2:       return longint'(od2);
      3:       return longint'(od3);
      default: return longint'(od4);
    endcase
  endfunction

  function automatic int get_count(input int k);
    case (k)
      0:       return int'(oc0);
      1:       return int'(oc1);
      2:       return int'(oc2);
      3:       return int'(oc3);
      default: return int'(oc4);
    endcase
  endfunction

  // Reference model: ideal integer sum, clamped or wrapped into the
  // representable range after each beat; count capped at max_len.
  function automatic void ref_vec(input int b[8], input int n, input bit sgn, input bit sat,
                                  input int wacc, input int max_len,
                                  output longint data, output int cnt,
                                  output bit ovf, output bit lerr);
    longint modv, lo, hi, acc, x;
    modv = longint'(1) << wacc;
    lo   = sgn ? -(modv / 2) : 64'sd0;
    hi   = sgn ? (modv / 2) - 1 : modv - 1;
    acc  = 0;
    cnt  = 0;
    ovf  = 1'b0;
    lerr = 1'b0;
    for (int i = 0; i < n; i++) begin
      x = sgn ? longint'(shortint'(b[i])) : longint'(b[i] & 32'hFFFF);
      acc += x;
      if (acc > hi || acc < lo) begin
        ovf = 1'b1;
        if (sat) acc = (acc > hi) ? hi : lo;
        else     acc = (acc > hi) ? acc - modv : acc + modv;
      end
      if (cnt == max_len) lerr = 1'b1;
      else                cnt++;
    end
    data = acc & (modv - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Present one beat and hold it until instance k accepts it (bounded).
  task automatic send_beat(input int k, input int d, input bit last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d[15:0];
    in_last  = last;
    #1;
    while (!in_ready[k] && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      checks++; failures++;
      $display("FAIL send_beat_timeout dut=%0d in_ready stayed 0", k);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 5'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=00000", out_valid); end
    checks++; if (len_err !== 5'b0)   begin failures++; $display("FAIL reset_len_err got=%b exp=00000", len_err); end
    checks++; if (out_ovf !== 5'b0)   begin failures++; $display("FAIL reset_out_ovf got=%b exp=00000", out_ovf); end
    checks++; if (od0 !== 32'd0 || oc0 !== 9'd0) begin failures++; $display("FAIL reset_out_data got=%0h/%0d exp=0/0", od0, oc0); end
    checks++; if (in_ready !== 5'b11111) begin failures++; $display("FAIL reset_in_ready got=%b exp=11111", in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    send_beat(0, 3, 1'b0);
    send_beat(0, -5, 1'b0);
    send_beat(0, 10, 1'b0);
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid[0]); end
    send_beat(0, 7, 1'b1);
    checks++; if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid[0]); end
    checks++; if (od0 !== 32'd15)        begin failures++; $display("FAIL basic_data got=%0d exp=15", od0); end
    checks++; if (oc0 !== 9'd4)          begin failures++; $display("FAIL basic_count got=%0d exp=4", oc0); end
    checks++; if (out_ovf[0] !== 1'b0)   begin failures++; $display("FAIL basic_ovf got=%b exp=0", out_ovf[0]); end
    tick();
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL basic_transfer got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_beat(1, 32'h7FFF, 1'b0);
    send_beat(1, 1, 1'b1);
    checks++; if (od1 !== 16'h7FFF || out_ovf[1] !== 1'b1) begin failures++; $display("FAIL ovf_sat got=%0h/%b exp=7fff/1", od1, out_ovf[1]); end
    checks++; if (od2 !== 16'h8000 || out_ovf[2] !== 1'b1) begin failures++; $display("FAIL ovf_wrap got=%0h/%b exp=8000/1", od2, out_ovf[2]); end
    checks++; if (od4 !== 16'h8000 || out_ovf[4] !== 1'b0) begin failures++; $display("FAIL ovf_unsigned got=%0h/%b exp=8000/0", od4, out_ovf[4]); end
    checks++; if (oc1 !== 9'd2) begin failures++; $display("FAIL ovf_count got=%0d exp=2", oc1); end
    tick();
    // Unsigned saturation: 0xFFFF + 0x0002 clamps to all ones.
    send_beat(4, 32'hFFFF, 1'b0);
    send_beat(4, 2, 1'b1);
    checks++; if (od4 !== 16'hFFFF || out_ovf[4] !== 1'b1) begin failures++; $display("FAIL ovf_unsigned_sat got=%0h/%b exp=ffff/1", od4, out_ovf[4]); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    send_beat(0, 32'h123, 1'b1);
    checks++; if (out_valid[0] !== 1'b1 || od0 !== 32'h123) begin failures++; $display("FAIL stall_first got=%b/%0h exp=1/123", out_valid[0], od0); end
    in_valid = 1'b1; in_data = 16'd55; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready[0]); end
      tick();
      checks++; if (out_valid[0] !== 1'b1 || od0 !== 32'h123 || oc0 !== 9'd1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%0h/%0d exp=1/123/1", i, out_valid[0], od0, oc0); end
    end
    in_data = 16'd9; in_last = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", in_ready[0]); end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid[0] !== 1'b1 || od0 !== 32'd9 || oc0 !== 9'd1) begin failures++; $display("FAIL back_to_back got=%b/%0d/%0d exp=1/9/1", out_valid[0], od0, oc0); end
    tick();
    checks++; if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_flush();
    do_reset();
    send_beat(0, 1, 1'b0);
    send_beat(0, 2, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd100; in_last = 1'b0;
    #1;
    checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready[0]); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    send_beat(0, 4, 1'b1);
    checks++; if (od0 !== 32'd4 || oc0 !== 9'd1 || out_valid[0] !== 1'b1) begin failures++; $display("FAIL flush_result got=%0d/%0d/%b exp=4/1/1", od0, oc0, out_valid[0]); end
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid[0] !== 1'b1 || od0 !== 32'd4) begin failures++; $display("FAIL flush_pending got=%b/%0d exp=1/4", out_valid[0], od0); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_len();
    do_reset();
    for (int i = 0; i < 5; i++) send_beat(3, 1, i == 4);
    checks++; if (len_err[3] !== 1'b1) begin failures++; $display("FAIL len_err_set got=%b exp=1", len_err[3]); end
    checks++; if (oc3 !== 3'd4 || od3 !== 32'd5) begin failures++; $display("FAIL len_result got=%0d/%0d exp=4/5", oc3, od3); end
    tick();
    send_beat(3, 2, 1'b0);
    send_beat(3, 3, 1'b1);
    checks++; if (len_err[3] !== 1'b1 || oc3 !== 3'd2 || od3 !== 32'd5) begin failures++; $display("FAIL len_sticky got=%b/%0d/%0d exp=1/2/5", len_err[3], oc3, od3); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (len_err[3] !== 1'b0) begin failures++; $display("FAIL len_err_rst got=%b exp=0", len_err[3]); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    send_beat(0, 5, 1'b0);
    send_beat(0, 6, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid[0] !== 1'b0 || od0 !== 32'd0 || oc0 !== 9'd0 || out_ovf[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_vector got=%b/%0d/%0d exp=0/0/0", out_valid[0], od0, oc0); end
    out_ready = 1'b0;
    send_beat(0, 7, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid[0] !== 1'b0 || od0 !== 32'd0 || oc0 !== 9'd0) begin failures++; $display("FAIL rst_pending got=%b/%0d/%0d exp=0/0/0", out_valid[0], od0, oc0); end
    out_ready = 1'b1;
    send_beat(0, 2, 1'b0);
    send_beat(0, 2, 1'b1);
    checks++; if (od0 !== 32'd4 || oc0 !== 9'd2) begin failures++; $display("FAIL rst_after got=%0d/%0d exp=4/2", od0, oc0); end
    tick();
  endtask

  task automatic test_random(input int k, input int nvec);
    int     beats[8];
    int     n, exp_cnt, stall;
    longint exp_data;
    bit     exp_ovf, exp_lerr, sticky;
    do_reset();
    sticky = 1'b0;
    for (int v = 0; v < nvec; v++) begin
      n = (k == 3) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 5));
      for (int i = 0; i < 8; i++) beats[i] = 0;
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       beats[i] = 32'h7FFF;
          1:       beats[i] = 32'h8000;
          default: beats[i] = int'($urandom_range(0, 65535));
        endcase
      end
      ref_vec(beats, n, cfg_sgn(k), cfg_sat(k), cfg_wacc(k), cfg_max(k),
              exp_data, exp_cnt, exp_ovf, exp_lerr);
      sticky |= exp_lerr;
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 1)) tick();
        send_beat(k, beats[i], i == n - 1);
      end
      checks++; if (out_valid[k] !== 1'b1) begin failures++; $display("FAIL rand_valid dut=%0d vec=%0d got=%b exp=1", k, v, out_valid[k]); end
      checks++; if (get_data(k) !== exp_data) begin failures++; $display("FAIL rand_data dut=%0d vec=%0d got=%0h exp=%0h", k, v, get_data(k), exp_data); end
      checks++; if (get_count(k) !== exp_cnt) begin failures++; $display("FAIL rand_count dut=%0d vec=%0d got=%0d exp=%0d", k, v, get_count(k), exp_cnt); end
      checks++; if (out_ovf[k] !== exp_ovf) begin failures++; $display("FAIL rand_ovf dut=%0d vec=%0d got=%b exp=%b", k, v, out_ovf[k], exp_ovf); end
      checks++; if (len_err[k] !== sticky) begin failures++; $display("FAIL rand_len_err dut=%0d vec=%0d got=%b exp=%b", k, v, len_err[k], sticky); end
      out_ready = 1'b0;
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        tick();
        checks++; if (out_valid[k] !== 1'b1 || get_data(k) !== exp_data) begin failures++; $display("FAIL rand_hold dut=%0d vec=%0d got=%0h exp=%0h", k, v, get_data(k), exp_data); end
      end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL rand_drain dut=%0d vec=%0d got=%b exp=0", k, v, out_valid[k]); end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_flush();
    test_len();
    test_rst_mid();
    for (int k = 0; k < 5; k++) test_random(k, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
